fb_arbiter: RTL
===============

FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 Parameter WORDS_PER_LINE, default 80, SHALL set the number of 24-bit words (8 px x 3 bit) per visible line.
REQ-002 Parameter V_VIDEO, default 480, SHALL set the number of visible lines; parameter V_TOTAL, default 525, SHALL set the total lines per frame.
REQ-003 clk  in  1  system clock (10x pixel clock).
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 line_start  in  1  single-cycle pulse at start of horizontal blanking of line line_y.
REQ-006 line_y  in  10  current line index, valid when line_start=1.
REQ-007 mem_addr  out  16  framebuffer single-port RAM address.
REQ-008 mem_we  out  1  RAM write enable.
REQ-009 mem_wdata  out  24  RAM write data.
REQ-010 mem_rdata  in  24  RAM read data, fixed 1-cycle read latency.
REQ-011 lb_we  out  1  line-buffer write enable.
REQ-012 lb_addr  out  7  line-buffer word index.
REQ-013 lb_wdata  out  24  line-buffer write data.
REQ-014 wr_valid  in  1  writer request valid.
REQ-015 wr_ready  out  1  writer request accepted this cycle when wr_valid=1.
REQ-016 wr_addr  in  16  writer word address.
REQ-017 wr_data  in  24  writer word data.
REQ-018 overrun  out  1  sticky: line_start arrived while a fetch was in progress.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, FETCH, DRAIN.
REQ-020 The next line SHALL be n = line_y+1 for line_y < V_VIDEO-1, and n = 0 for line_y = V_TOTAL-1; any other line_y SHALL start no fetch.
REQ-021 When line_start=1 with a valid n in IDLE, the block SHALL go to FETCH next cycle with base = n*WORDS_PER_LINE (16-bit, shift-add) and word count 0.
REQ-022 In FETCH, each cycle: mem_addr = base+count, mem_we=0, count+1; after the count WORDS_PER_LINE-1 issue, the FSM SHALL go to DRAIN.
REQ-023 lb_we SHALL be 1 exactly one cycle after each FETCH read, with lb_addr = that read's count and lb_wdata = mem_rdata.
REQ-024 DRAIN SHALL last one cycle (final lb_we) and then return to IDLE; a fetch therefore occupies WORDS_PER_LINE+1 cycles after entry.
REQ-025 wr_ready SHALL equal (state==IDLE) && !(line_start && valid n); a fetch wins any simultaneous conflict.
REQ-026 On wr_valid && wr_ready, in the same cycle: mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data.
REQ-027 In IDLE without a transfer: mem_we=0, mem_addr holds its last value.
REQ-028 line_start during FETCH or DRAIN SHALL be ignored for fetching, and SHALL set overrun=1 until reset.
REQ-029 wr_addr beyond 38399 SHALL still be written unmodified; range checks belong to the writer.

Reset
REQ-030 While rst=1: state IDLE, count 0, mem_we=0, lb_we=0, wr_ready=0, overrun=0, mem_addr=0, lb_addr=0.
REQ-031 rst asserted mid-FETCH SHALL abort the fetch; lb_we SHALL be 0 from the cycle after rst is sampled.

Structure
REQ-032 Package fb_pkg SHALL hold V_VIDEO, V_TOTAL, WORDS_PER_LINE, ADDR_W=16, DATA_W=24, and the FSM state enum.
REQ-033 Sub-module fb_line_addr SHALL compute n*WORDS_PER_LINE combinationally; everything else stays in fb_arbiter.

Verification
REQ-034 line_start with line_y=9 -> 80 reads, addr 800..879 on consecutive cycles; lb_we 80 cycles, lb_addr 0..79; IDLE 82 cycles after the pulse.
REQ-035 line_start with line_y=524 -> fetch from addr 0..79; line_y=479 or 500 -> no fetch, wr_ready stays 1.
REQ-036 wr_valid held during a fetch with wr_addr=0x1234, wr_data=0xABCDEF -> wr_ready=0 until IDLE; write then occurs with mem_we=1 in the first IDLE cycle.
REQ-037 line_start and wr_valid in the same IDLE cycle -> wr_ready=0, fetch starts, write completes after DRAIN.
REQ-038 Second line_start 40 cycles into a fetch -> overrun=1 and stays set; the first fetch completes all 80 words; rst clears overrun.
REQ-039 rst pulsed at word 30 of a fetch -> lb_we=0 from the next cycle, wr_ready=0 during rst, IDLE with wr_ready=1 after release.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and FSM state encoding for the framebuffer line-fetch arbiter.
package fb_pkg;
    localparam int V_VIDEO        = 480;
    localparam int V_TOTAL        = 525;
    localparam int WORDS_PER_LINE = 80;
    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 24;
    localparam int LINE_W         = 10;
    localparam int LB_ADDR_W      = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fb_state_e;
endpackage

// File: rtl/fb_line_addr.sv
// Line base address: line index times the words per line, built as a
// constant shift-add so no multiplier is inferred.
module fb_line_addr #(
    parameter int WORDS_PER_LINE = fb_pkg::WORDS_PER_LINE
) (
    input  logic [fb_pkg::LINE_W-1:0] line_i,
    output logic [fb_pkg::ADDR_W-1:0] base_o
);
    import fb_pkg::*;

    localparam logic [ADDR_W-1:0] MULT = ADDR_W'(WORDS_PER_LINE);

    logic [ADDR_W-1:0] line_ext;

    assign line_ext = ADDR_W'(line_i);

    always_comb begin
        base_o = '0;
        for (int i = 0; i < ADDR_W; i++) begin
            if (MULT[i]) begin
                base_o = base_o + (line_ext << i);
            end
        end
    end
endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: copies the next visible line into the line buffer
// during horizontal blanking and gives the RAM port to the pixel writer otherwise.
module fb_arbiter #(
    parameter int WORDS_PER_LINE = fb_pkg::WORDS_PER_LINE,
    parameter int V_VIDEO        = fb_pkg::V_VIDEO,
    parameter int V_TOTAL        = fb_pkg::V_TOTAL
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         line_start,
    input  logic [fb_pkg::LINE_W-1:0]    line_y,
    output logic [fb_pkg::ADDR_W-1:0]    mem_addr,
    output logic                         mem_we,
    output logic [fb_pkg::DATA_W-1:0]    mem_wdata,
    input  logic [fb_pkg::DATA_W-1:0]    mem_rdata,
    output logic                         lb_we,
    output logic [fb_pkg::LB_ADDR_W-1:0] lb_addr,
    output logic [fb_pkg::DATA_W-1:0]    lb_wdata,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [fb_pkg::ADDR_W-1:0]    wr_addr,
    input  logic [fb_pkg::DATA_W-1:0]    wr_data,
    output logic                         overrun,
    output fb_pkg::fb_state_e            dbg_state
);
    import fb_pkg::*;

    localparam logic [LB_ADDR_W-1:0] LAST_WORD    = LB_ADDR_W'(WORDS_PER_LINE - 1);
    localparam logic [LINE_W-1:0]    LAST_VISIBLE = LINE_W'(V_VIDEO - 1);
    localparam logic [LINE_W-1:0]    LAST_LINE    = LINE_W'(V_TOTAL - 1);

    fb_state_e            state_q;
    logic [LB_ADDR_W-1:0] count_q;
    logic [LB_ADDR_W-1:0] rd_idx_q;
    logic                 rd_pend_q;
    logic [ADDR_W-1:0]    base_q;
    logic [ADDR_W-1:0]    addr_hold_q;
    logic                 overrun_q;

    logic [LINE_W-1:0]    next_line;
    logic                 next_valid;
    logic [ADDR_W-1:0]    line_base;
    logic                 fetch_start;
    logic                 wr_fire;

    // Only the visible lines have a successor to prefetch; the last frame line wraps to 0.
    always_comb begin
        next_valid = 1'b0;
        next_line  = '0;
        if (line_y < LAST_VISIBLE) begin
            next_valid = 1'b1;
            next_line  = line_y + LINE_W'(1);
        end else if (line_y == LAST_LINE) begin
            next_valid = 1'b1;
        end
    end

    fb_line_addr #(
        .WORDS_PER_LINE(WORDS_PER_LINE)
    ) u_line_addr (
        .line_i(next_line),
        .base_o(line_base)
    );

    // Writer handshake: a write transfers in every cycle where wr_valid and
    // wr_ready are both high; wr_valid may be held as long as needed and the
    // request stays pending while wr_ready is low. A starting fetch takes priority.
    assign fetch_start = (state_q == IDLE) && line_start && next_valid;
    assign wr_ready    = !rst && (state_q == IDLE) && !(line_start && next_valid);
    assign wr_fire     = wr_valid && wr_ready;
    assign mem_we      = wr_fire;
    assign mem_wdata   = wr_data;

    always_comb begin
        mem_addr = addr_hold_q;
        if (rst) begin
            mem_addr = '0;
        end else if (state_q == FETCH) begin
            mem_addr = base_q + ADDR_W'(count_q);
        end else if (wr_fire) begin
            mem_addr = wr_addr;
        end
    end

    // Read data arrives one cycle after the address, so the buffer write trails by one.
    assign lb_we     = rd_pend_q && !rst;
    assign lb_addr   = rst ? '0 : rd_idx_q;
    assign lb_wdata  = mem_rdata;
    assign overrun   = overrun_q && !rst;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            base_q      <= '0;
            rd_pend_q   <= 1'b0;
            rd_idx_q    <= '0;
            addr_hold_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            addr_hold_q <= mem_addr;
            rd_pend_q   <= (state_q == FETCH);
            rd_idx_q    <= count_q;
            if (line_start && (state_q != IDLE)) begin
                overrun_q <= 1'b1;
            end
            case (state_q)
                IDLE: begin
                    if (fetch_start) begin
                        state_q <= FETCH;
                        base_q  <= line_base;
                        count_q <= '0;
                    end
                end
                FETCH: begin
                    count_q <= count_q + LB_ADDR_W'(1);
                    if (count_q == LAST_WORD) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule
